// File: rtl/vdg_row_address_gen.sv
// Mode-aware display address sequencer for the MC6847X video core.
// Steps the display address once per fetch strobe, caps each scan line at
// the mode's byte width and replays each memory row 1, 2, 3 or 12 times.
//
// Strobe semantics: frame_start, line_end and fetch are single-cycle pulses
// with no back-pressure; each one is acted on at the clock edge where it is
// high. Within one cycle reset > frame_start > line_end > fetch, and a
// lower-priority strobe coincident with a higher one is dropped.
module vdg_row_address_gen #(
    parameter int ADDR_WIDTH   = 13,
    parameter int BYTES_WIDE   = 32,
    parameter int BYTES_NARROW = 16,
    parameter int ALPHA_REPEAT = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  line_end,
    input  logic                  fetch,
    input  logic                  ag,
    input  logic [2:0]            gm,
    output logic [ADDR_WIDTH-1:0] da,
    output logic [3:0]            char_row,
    output logic                  row_done,
    output logic                  group_last
);

    localparam int CNT_W = $clog2(BYTES_WIDE + 1);

    logic [ADDR_WIDTH-1:0] row_base;
    logic [CNT_W-1:0]      byte_cnt;
    logic [CNT_W-1:0]      bytes_q;
    logic [3:0]            rep_q;
    logic [CNT_W-1:0]      dec_bytes;
    logic [3:0]            dec_rep;
    logic [ADDR_WIDTH-1:0] next_base;

    // Decode the live ag/gm inputs into (bytes per row, scan-line repeat).
    always_comb begin
        dec_bytes = CNT_W'(BYTES_WIDE);
        dec_rep   = 4'(ALPHA_REPEAT);
        if (ag) begin
            case (gm)
                3'd0, 3'd1: begin dec_bytes = CNT_W'(BYTES_NARROW); dec_rep = 4'd3; end
                3'd2:       begin dec_bytes = CNT_W'(BYTES_WIDE);   dec_rep = 4'd3; end
                3'd3:       begin dec_bytes = CNT_W'(BYTES_NARROW); dec_rep = 4'd2; end
                3'd4:       begin dec_bytes = CNT_W'(BYTES_WIDE);   dec_rep = 4'd2; end
                3'd5:       begin dec_bytes = CNT_W'(BYTES_NARROW); dec_rep = 4'd1; end
                default:    begin dec_bytes = CNT_W'(BYTES_WIDE);   dec_rep = 4'd1; end
            endcase
        end
    end

    // Start of the next memory row uses the width of the line that is ending.
    assign next_base = row_base + ADDR_WIDTH'(bytes_q);

    // Address, byte counter, repeat index and latched mode registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_base <= '0;
            da       <= '0;
            byte_cnt <= '0;
            char_row <= '0;
            bytes_q  <= CNT_W'(BYTES_WIDE);
            rep_q    <= 4'(ALPHA_REPEAT);
        end else if (frame_start) begin
            row_base <= '0;
            da       <= '0;
            byte_cnt <= '0;
            char_row <= '0;
            bytes_q  <= dec_bytes;
            rep_q    <= dec_rep;
        end else if (line_end) begin
            bytes_q  <= dec_bytes;
            rep_q    <= dec_rep;
            byte_cnt <= '0;
            // >= rather than == so a repeat count that shrinks mid-group
            // still closes the group instead of running past it.
            if (char_row >= dec_rep - 4'd1) begin
                char_row <= '0;
                row_base <= next_base;
                da       <= next_base;
            end else begin
                char_row <= char_row + 4'd1;
                da       <= row_base;
            end
        end else if (fetch && (byte_cnt < bytes_q)) begin
            da       <= da + ADDR_WIDTH'(1);
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    // Status flags depend on registers only.
    assign row_done   = (byte_cnt >= bytes_q);
    assign group_last = (char_row == rep_q - 4'd1);

endmodule

// File: tb/tb_vdg_row_address_gen.sv
// Directed testbench for vdg_row_address_gen.
module tb_vdg_row_address_gen;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        line_end;
    logic        fetch;
    logic        ag;
    logic [2:0]  gm;
    logic [12:0] da;
    logic [3:0]  char_row;
    logic        row_done;
    logic        group_last;

    int n_checks = 0;
    int n_fail   = 0;

    vdg_row_address_gen #(
        .ADDR_WIDTH(13), .BYTES_WIDE(32), .BYTES_NARROW(16), .ALPHA_REPEAT(12)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_end(line_end),
        .fetch(fetch), .ag(ag), .gm(gm), .da(da), .char_row(char_row),
        .row_done(row_done), .group_last(group_last)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change and outputs are sampled on the falling edge.
    task automatic do_fetch(input int n);
        @(negedge clk);
        fetch = 1'b1;
        repeat (n) @(negedge clk);
        fetch = 1'b0;
    endtask

    task automatic do_line_end(input int n);
        @(negedge clk);
        line_end = 1'b1;
        repeat (n) @(negedge clk);
        line_end = 1'b0;
    endtask

    task automatic do_frame_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        ag = 1'b1; gm = 3'd7;
        @(negedge clk);
        reset = 1'b1; fetch = 1'b1; line_end = 1'b1; frame_start = 1'b1;
        repeat (2) @(negedge clk);
        fetch = 1'b0; line_end = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd0 || row_done !== 1'b0 || group_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: da=%0d char_row=%0d row_done=%b group_last=%b, need 0/0/0/0",
                     da, char_row, row_done, group_last);
        end
        // Mode after reset is alpha (32 bytes) even with ag=1 gm=7 applied.
        do_fetch(40);
        n_checks++;
        if (da !== 13'd32 || row_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mode_alpha: da=%0d row_done=%b, need 32/1", da, row_done);
        end
    endtask

    task automatic test_alpha();
        ag = 1'b0; gm = 3'd0;
        do_frame_start();
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd0) begin
            n_fail++;
            $display("FAIL alpha_frame_start: da=%0d char_row=%0d, need 0/0", da, char_row);
        end
        for (int k = 1; k <= 11; k++) begin
            do_fetch(32);
            n_checks++;
            if (da !== 13'd32 || row_done !== 1'b1) begin
                n_fail++;
                $display("FAIL alpha_fetch line %0d: da=%0d row_done=%b, need 32/1", k, da, row_done);
            end
            do_line_end(1);
            n_checks++;
            if (da !== 13'd0 || char_row !== 4'(k) || row_done !== 1'b0 || group_last !== (k == 11)) begin
                n_fail++;
                $display("FAIL alpha_replay %0d: da=%0d char_row=%0d row_done=%b group_last=%b, need 0/%0d/0/%b",
                         k, da, char_row, row_done, group_last, k, (k == 11));
            end
        end
        do_fetch(32);
        do_line_end(1);
        n_checks++;
        if (da !== 13'd32 || char_row !== 4'd0 || group_last !== 1'b0) begin
            n_fail++;
            $display("FAIL alpha_advance: da=%0d char_row=%0d group_last=%b, need 32/0/0", da, char_row, group_last);
        end
    endtask

    task automatic test_narrow();
        ag = 1'b1; gm = 3'd3;
        do_frame_start();
        do_fetch(20);
        n_checks++;
        if (da !== 13'd16 || row_done !== 1'b1) begin
            n_fail++;
            $display("FAIL narrow_saturate: da=%0d row_done=%b, need 16/1", da, row_done);
        end
        do_line_end(1);
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd1 || row_done !== 1'b0 || group_last !== 1'b1) begin
            n_fail++;
            $display("FAIL narrow_replay: da=%0d char_row=%0d row_done=%b group_last=%b, need 0/1/0/1",
                     da, char_row, row_done, group_last);
        end
        do_line_end(1);
        n_checks++;
        if (da !== 13'd16 || char_row !== 4'd0) begin
            n_fail++;
            $display("FAIL narrow_advance: da=%0d char_row=%0d, need 16/0", da, char_row);
        end
    endtask

    task automatic test_gm7_frame();
        logic bad;
        bad = 1'b0;
        ag = 1'b1; gm = 3'd7;
        do_frame_start();
        n_checks++;
        if (group_last !== 1'b1 || char_row !== 4'd0) begin
            n_fail++;
            $display("FAIL gm7_start: group_last=%b char_row=%0d, need 1/0", group_last, char_row);
        end
        for (int l = 0; l < 192; l++) begin
            do_fetch(32);
            if (row_done !== 1'b1 || group_last !== 1'b1 || char_row !== 4'd0) bad = 1'b1;
            do_line_end(1);
            if (da !== 13'((l + 1) * 32) || char_row !== 4'd0 || group_last !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL gm7_lines: a per-line address/char_row/group_last value was wrong (flag=%b, need 0)", bad);
        end
        n_checks++;
        if (da !== 13'h1800) begin
            n_fail++;
            $display("FAIL gm7_final_da: da=%0d, need 6144", da);
        end
    endtask

    task automatic test_mode_change();
        ag = 1'b1; gm = 3'd0;
        do_frame_start();
        do_line_end(1);
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd1) begin
            n_fail++;
            $display("FAIL mode_first_replay: da=%0d char_row=%0d, need 0/1", da, char_row);
        end
        gm = 3'd5;
        do_fetch(20);
        n_checks++;
        if (da !== 13'd16 || row_done !== 1'b1 || group_last !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_midline: da=%0d row_done=%b group_last=%b, need 16/1/0", da, row_done, group_last);
        end
        do_line_end(1);
        n_checks++;
        if (da !== 13'd16 || char_row !== 4'd0 || group_last !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_shrink: da=%0d char_row=%0d group_last=%b, need 16/0/1", da, char_row, group_last);
        end
    endtask

    task automatic test_back_to_back();
        ag = 1'b1; gm = 3'd4;
        do_frame_start();
        do_fetch(5);
        n_checks++;
        if (da !== 13'd5) begin
            n_fail++;
            $display("FAIL b2b_fetch: da=%0d, need 5", da);
        end
        @(negedge clk);
        fetch = 1'b1; line_end = 1'b1;
        @(negedge clk);
        fetch = 1'b0; line_end = 1'b0;
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd1 || row_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_with_line_end: da=%0d char_row=%0d row_done=%b, need 0/1/0", da, char_row, row_done);
        end
        do_fetch(3);
        @(negedge clk);
        fetch = 1'b1; line_end = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        fetch = 1'b0; line_end = 1'b0; frame_start = 1'b0;
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd0 || row_done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_start_wins: da=%0d char_row=%0d row_done=%b, need 0/0/0", da, char_row, row_done);
        end
    endtask

    task automatic test_wrap_and_reset();
        ag = 1'b1; gm = 3'd5;
        do_frame_start();
        do_line_end(511);
        n_checks++;
        if (da !== 13'd8176) begin
            n_fail++;
            $display("FAIL wrap_preset: da=%0d, need 8176", da);
        end
        do_fetch(16);
        n_checks++;
        if (da !== 13'd0 || row_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_fetch: da=%0d row_done=%b, need 0/1", da, row_done);
        end
        do_line_end(1);
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_row_base: da=%0d char_row=%0d, need 0/0", da, char_row);
        end
        do_fetch(5);
        @(negedge clk);
        reset = 1'b1; fetch = 1'b1;
        @(negedge clk);
        n_checks++;
        if (da !== 13'd0 || char_row !== 4'd0 || row_done !== 1'b0 || group_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midline_reset: da=%0d char_row=%0d row_done=%b group_last=%b, need 0/0/0/0",
                     da, char_row, row_done, group_last);
        end
        reset = 1'b0; fetch = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; line_end = 1'b0; fetch = 1'b0;
        ag = 1'b0; gm = 3'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_alpha();
        test_narrow();
        test_gm7_frame();
        test_mode_change();
        test_back_to_back();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
